// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the SRAM-like N:1 arbiter: transfer size encodings,
// arbitration mode selectors and a constant-evaluable clog2 helper.
package sram_like_arbiter_pkg;

  // Transfer size encodings carried on up_size / dn_size
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Arbitration modes
  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Ceiling log2; returns 0 for values <= 1
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// outst_id_fifo: tracks the channel id of every accepted-but-unreturned
// transaction so returns are routed back in issue order.
// Ports:
//   clk, resetn   clock / synchronous active-low reset
//   push, push_id enqueue a channel id (ignored when full)
//   pop           dequeue the head entry (ignored when empty)
//   head_id       id of the oldest outstanding transaction
//   count         number of stored entries (0..DEPTH)
module outst_id_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter int unsigned ID_W  = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    push,
  input  logic [ID_W-1:0]         push_id,
  input  logic                    pop,
  output logic [ID_W-1:0]         head_id,
  output logic [clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [ID_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Next-state: pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_push  = push && (count_q != CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
    end
    if (do_pop) begin
      rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = CNT_W'(count_q + 1'b1);
      2'b01:   count_d = CNT_W'(count_q - 1'b1);
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_id = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges NUM_CH SRAM-like master ports onto one SRAM-like
// slave port. Address phase is a zero-latency mux of the granted channel;
// returns are steered back to the issuing channel through an id FIFO.
// Ports:
//   up_*        per-channel master requests (packed, channel i at slice i)
//   up_addr_ok  one-hot accept to the granted channel
//   up_data_ok  one-hot return to the oldest outstanding channel
//   up_rdata    slave read data broadcast to all channels
//   dn_*        slave request / response
//   outst_cnt   accepted-but-unreturned transaction count
//   proto_err   sticky flag: slave returned data with nothing outstanding
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned ARB_MODE  = ARB_FIXED
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_CH-1:0]          up_req,
  input  logic [NUM_CH-1:0]          up_wr,
  input  logic [2*NUM_CH-1:0]        up_size,
  input  logic [4*NUM_CH-1:0]        up_wstrb,
  input  logic [ADDR_W*NUM_CH-1:0]   up_addr,
  input  logic [DATA_W*NUM_CH-1:0]   up_wdata,
  output logic [NUM_CH-1:0]          up_addr_ok,
  output logic [NUM_CH-1:0]          up_data_ok,
  output logic [DATA_W-1:0]          up_rdata,
  output logic                       dn_req,
  output logic                       dn_wr,
  output logic [1:0]                 dn_size,
  output logic [3:0]                 dn_wstrb,
  output logic [ADDR_W-1:0]          dn_addr,
  output logic [DATA_W-1:0]          dn_wdata,
  input  logic                       dn_addr_ok,
  input  logic                       dn_data_ok,
  input  logic [DATA_W-1:0]          dn_rdata,
  output logic [clog2(MAX_OUTST):0]  outst_cnt,
  output logic                       proto_err
);

  localparam int unsigned ID_W  = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);
  localparam int unsigned CNT_W = clog2(MAX_OUTST) + 1;

  logic              lock_q, lock_d;
  logic [ID_W-1:0]   lock_id_q, lock_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              proto_err_q, proto_err_d;

  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic              full;
  logic              accept;
  logic              pop;
  logic [ID_W-1:0]   head_id;
  logic [CNT_W-1:0]  count;

  // Grant selection; a pending lock pins the grant to the stalled channel
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    if (lock_q) begin
      grant_id  = lock_id_q;
      grant_vld = up_req[lock_id_q];
    end else if (ARB_MODE == ARB_RR) begin
      // Scan offsets high to low so the nearest requester after rr_ptr wins
      for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= int'(NUM_CH)) idx = idx - int'(NUM_CH);
        if (up_req[ID_W'(idx)]) begin
          grant_vld = 1'b1;
          grant_id  = ID_W'(idx);
        end
      end
    end else begin
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
        if (up_req[i]) begin
          grant_vld = 1'b1;
          grant_id  = ID_W'(i);
        end
      end
    end
  end

  // Request field mux of the granted channel
  always_comb begin
    dn_wr    = 1'b0;
    dn_size  = '0;
    dn_wstrb = '0;
    dn_addr  = '0;
    dn_wdata = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (grant_id == ID_W'(i)) begin
        dn_wr    = up_wr[i];
        dn_size  = up_size[2*i +: 2];
        dn_wstrb = up_wstrb[4*i +: 4];
        dn_addr  = up_addr[ADDR_W*i +: ADDR_W];
        dn_wdata = up_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  // Handshakes; a full tracker blocks issue even if a return pops this cycle
  always_comb begin
    full       = (count == CNT_W'(MAX_OUTST));
    dn_req     = grant_vld && !full;
    accept     = dn_req && dn_addr_ok;
    pop        = dn_data_ok && (count != '0);
    up_addr_ok = accept ? (NUM_CH'(1) << grant_id) : '0;
    up_data_ok = pop ? (NUM_CH'(1) << head_id) : '0;
    up_rdata   = dn_rdata;
    outst_cnt  = count;
    proto_err  = proto_err_q;
  end

  // Lock, round-robin pointer and error flag next-state
  always_comb begin
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
    rr_ptr_d    = rr_ptr_q;
    proto_err_d = proto_err_q;
    if (accept) begin
      lock_d = 1'b0;
      if (ARB_MODE == ARB_RR) begin
        rr_ptr_d = (grant_id == ID_W'(NUM_CH - 1)) ? '0 : ID_W'(grant_id + 1'b1);
      end
    end else if (dn_req) begin
      lock_d    = 1'b1;
      lock_id_d = grant_id;
    end
    if (dn_data_ok && (count == '0)) proto_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
      rr_ptr_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      rr_ptr_q    <= rr_ptr_d;
      proto_err_q <= proto_err_d;
    end
  end

  outst_id_fifo #(
    .ID_W  (ID_W),
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (accept),
    .push_id (grant_id),
    .pop     (pop),
    .head_id (head_id),
    .count   (count)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: a fixed-priority 2-channel instance and a
// round-robin 3-channel instance, each checked every cycle against a
// queue-based reference model plus directed literal expectations.
module tb_sram_like_arbiter;

  localparam int MO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  // Fixed-priority instance (NUM_CH=2)
  logic [1:0]  f_req, f_wr, f_up_aok, f_up_dok;
  logic [3:0]  f_size;
  logic [7:0]  f_wstrb;
  logic [63:0] f_addr, f_wdata;
  logic [31:0] f_up_rdata, f_dn_addr, f_dn_wdata, f_dn_rdata;
  logic        f_dn_req, f_dn_wr, f_aok, f_dok, f_perr;
  logic [1:0]  f_dn_size;
  logic [3:0]  f_dn_wstrb;
  logic [2:0]  f_cnt;

  // Round-robin instance (NUM_CH=3)
  logic [2:0]  r_req, r_wr, r_up_aok, r_up_dok;
  logic [5:0]  r_size;
  logic [11:0] r_wstrb;
  logic [95:0] r_addr, r_wdata;
  logic [31:0] r_up_rdata, r_dn_addr, r_dn_wdata, r_dn_rdata;
  logic        r_dn_req, r_dn_wr, r_aok, r_dok, r_perr;
  logic [1:0]  r_dn_size;
  logic [3:0]  r_dn_wstrb;
  logic [2:0]  r_cnt;

  sram_like_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(MO), .ARB_MODE(0)) u_fix (
    .clk(clk), .resetn(resetn),
    .up_req(f_req), .up_wr(f_wr), .up_size(f_size), .up_wstrb(f_wstrb),
    .up_addr(f_addr), .up_wdata(f_wdata),
    .up_addr_ok(f_up_aok), .up_data_ok(f_up_dok), .up_rdata(f_up_rdata),
    .dn_req(f_dn_req), .dn_wr(f_dn_wr), .dn_size(f_dn_size), .dn_wstrb(f_dn_wstrb),
    .dn_addr(f_dn_addr), .dn_wdata(f_dn_wdata),
    .dn_addr_ok(f_aok), .dn_data_ok(f_dok), .dn_rdata(f_dn_rdata),
    .outst_cnt(f_cnt), .proto_err(f_perr)
  );

  sram_like_arbiter #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(MO), .ARB_MODE(1)) u_rr (
    .clk(clk), .resetn(resetn),
    .up_req(r_req), .up_wr(r_wr), .up_size(r_size), .up_wstrb(r_wstrb),
    .up_addr(r_addr), .up_wdata(r_wdata),
    .up_addr_ok(r_up_aok), .up_data_ok(r_up_dok), .up_rdata(r_up_rdata),
    .dn_req(r_dn_req), .dn_wr(r_dn_wr), .dn_size(r_dn_size), .dn_wstrb(r_dn_wstrb),
    .dn_addr(r_dn_addr), .dn_wdata(r_dn_wdata),
    .dn_addr_ok(r_aok), .dn_data_ok(r_dok), .dn_rdata(r_dn_rdata),
    .outst_cnt(r_cnt), .proto_err(r_perr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model state per instance (0 = fixed, 1 = round-robin)
  bit m_valid[2];
  bit m_lock[2];
  int m_lid[2];
  int m_rr[2];
  int m_q[2][8];
  int m_n[2];
  bit m_perr[2];

  task automatic model_step(
    input int k, input int nch, input bit rr_mode, input logic rst,
    input logic [2:0] req, input logic [2:0] wr, input logic [5:0] size,
    input logic [11:0] wstrb, input logic [95:0] addr, input logic [95:0] wdata,
    input logic aok, input logic dok, input logic [31:0] rdata,
    input logic [2:0] g_aok, input logic [2:0] g_dok, input logic [31:0] g_rdata,
    input logic g_req, input logic g_wr, input logic [1:0] g_size, input logic [3:0] g_wstrb,
    input logic [31:0] g_addr, input logic [31:0] g_wdata,
    input logic [2:0] g_cnt, input logic g_perr);
    string p;
    int g, c;
    bit gv, ereq, acc, pp;
    p = (k == 0) ? "fix" : "rr";
    if (!rst) begin
      m_valid[k] = 1'b1; m_lock[k] = 1'b0; m_lid[k] = 0; m_rr[k] = 0;
      m_n[k] = 0; m_perr[k] = 1'b0;
      return;
    end
    if (!m_valid[k]) return;
    g = 0; gv = 1'b0;
    if (m_lock[k]) begin
      g = m_lid[k]; gv = req[g];
    end else begin
      for (int j = 0; j < nch; j++) begin
        c = rr_mode ? (m_rr[k] + j) % nch : j;
        if (!gv && req[c]) begin g = c; gv = 1'b1; end
      end
    end
    ereq = gv && (m_n[k] < MO);
    acc  = ereq && aok;
    pp   = dok && (m_n[k] > 0);
    chk({p, ".m.dn_req"},     32'(g_req),  32'(ereq));
    chk({p, ".m.up_addr_ok"}, 32'(g_aok),  acc ? (32'd1 << g) : 32'd0);
    chk({p, ".m.up_data_ok"}, 32'(g_dok),  pp ? (32'd1 << m_q[k][0]) : 32'd0);
    chk({p, ".m.outst_cnt"},  32'(g_cnt),  32'(m_n[k]));
    chk({p, ".m.proto_err"},  32'(g_perr), 32'(m_perr[k]));
    if (ereq) begin
      chk({p, ".m.dn_addr"},  g_addr,           addr[g*32 +: 32]);
      chk({p, ".m.dn_wdata"}, g_wdata,          wdata[g*32 +: 32]);
      chk({p, ".m.dn_wr"},    32'(g_wr),        32'(wr[g]));
      chk({p, ".m.dn_size"},  32'(g_size),      32'(size[g*2 +: 2]));
      chk({p, ".m.dn_wstrb"}, 32'(g_wstrb),     32'(wstrb[g*4 +: 4]));
    end
    if (pp) chk({p, ".m.up_rdata"}, g_rdata, rdata);
    // Advance: retire oldest, append newly accepted id in issue order
    if (pp) begin
      for (int j = 0; j < 7; j++) m_q[k][j] = m_q[k][j+1];
      m_n[k]--;
    end
    if (acc) begin
      m_q[k][m_n[k]] = g;
      m_n[k]++;
      m_lock[k] = 1'b0;
      if (rr_mode) m_rr[k] = (g + 1) % nch;
    end else if (ereq) begin
      m_lock[k] = 1'b1; m_lid[k] = g;
    end
    if (dok && m_n[k] == 0 && !pp) m_perr[k] = 1'b1;
  endtask

  // Per-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    model_step(0, 2, 1'b0, resetn, {1'b0, f_req}, {1'b0, f_wr}, {2'b0, f_size},
               {4'b0, f_wstrb}, {32'b0, f_addr}, {32'b0, f_wdata}, f_aok, f_dok, f_dn_rdata,
               {1'b0, f_up_aok}, {1'b0, f_up_dok}, f_up_rdata, f_dn_req, f_dn_wr,
               f_dn_size, f_dn_wstrb, f_dn_addr, f_dn_wdata, f_cnt, f_perr);
    model_step(1, 3, 1'b1, resetn, r_req, r_wr, r_size, r_wstrb, r_addr, r_wdata,
               r_aok, r_dok, r_dn_rdata, r_up_aok, r_up_dok, r_up_rdata, r_dn_req,
               r_dn_wr, r_dn_size, r_dn_wstrb, r_dn_addr, r_dn_wdata, r_cnt, r_perr);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int exp_g[6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    resetn = 1'b0;
    f_req = '0; f_wr = 2'b10; f_size = {2'd1, 2'd2}; f_wstrb = {4'b0011, 4'b1111};
    f_addr = {32'h1000_0100, 32'h1000_0000}; f_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
    f_aok = 1'b0; f_dok = 1'b0; f_dn_rdata = 32'h0;
    r_req = '0; r_wr = 3'b000; r_size = {2'd0, 2'd2, 2'd2}; r_wstrb = {4'b0100, 4'b1111, 4'b1111};
    r_addr = {32'h2000_0200, 32'h2000_0100, 32'h2000_0000};
    r_wdata = {32'hC2, 32'hC1, 32'hC0};
    r_aok = 1'b0; r_dok = 1'b0; r_dn_rdata = 32'h0;
    cyc(); cyc();
    resetn = 1'b1;
    #1;
    chk("lit.reset.dn_req",   32'(f_dn_req), 32'd0);
    chk("lit.reset.addr_ok",  32'(f_up_aok), 32'd0);
    chk("lit.reset.data_ok",  32'(f_up_dok), 32'd0);
    chk("lit.reset.cnt",      32'(f_cnt),    32'd0);
    chk("lit.reset.perr",     32'(f_perr),   32'd0);

    // Fixed priority: both request, ch0 wins, ch1 next; returns in order
    f_req = 2'b11; f_aok = 1'b1; #1;
    chk("lit.fp.aok0",  32'(f_up_aok), 32'h1);
    chk("lit.fp.addr0", f_dn_addr, 32'h1000_0000);
    cyc(); f_req = 2'b10; #1;
    chk("lit.fp.aok1",  32'(f_up_aok), 32'h2);
    chk("lit.fp.addr1", f_dn_addr, 32'h1000_0100);
    cyc(); f_req = 2'b00; f_aok = 1'b0; f_dok = 1'b1; f_dn_rdata = 32'hD0; #1;
    chk("lit.fp.dok0",  32'(f_up_dok), 32'h1);
    chk("lit.fp.rdata", f_up_rdata, 32'hD0);
    cyc(); f_dn_rdata = 32'hD1; #1;
    chk("lit.fp.dok1",  32'(f_up_dok), 32'h2);
    cyc(); f_dok = 1'b0; #1;
    chk("lit.fp.cnt",   32'(f_cnt), 32'd0);

    // Lock: ch1 stalled 3 cycles, ch0 arriving later must not preempt
    f_addr = {32'h1c00_0000, 32'h1fc0_0000};
    f_req = 2'b10; #1;
    chk("lit.lock.addr_c0", f_dn_addr, 32'h1c00_0000);
    cyc(); f_req = 2'b11; #1;
    chk("lit.lock.addr_c1", f_dn_addr, 32'h1c00_0000);
    cyc(); #1;
    chk("lit.lock.addr_c2", f_dn_addr, 32'h1c00_0000);
    cyc(); f_aok = 1'b1; #1;
    chk("lit.lock.aok_c3",  32'(f_up_aok), 32'h2);
    cyc(); f_req = 2'b01; #1;
    chk("lit.lock.aok_c4",  32'(f_up_aok), 32'h1);
    chk("lit.lock.addr_c4", f_dn_addr, 32'h1fc0_0000);
    cyc(); f_req = 2'b00; f_aok = 1'b0; f_dok = 1'b1; #1;
    chk("lit.lock.dok_a", 32'(f_up_dok), 32'h2);
    cyc(); #1;
    chk("lit.lock.dok_b", 32'(f_up_dok), 32'h1);
    cyc(); f_dok = 1'b0;

    // Locked channel drops its request: nothing issues until it returns
    f_req = 2'b10; cyc();
    f_req = 2'b01; #1;
    chk("lit.drop.dn_req", 32'(f_dn_req), 32'd0);
    cyc(); f_req = 2'b11; f_aok = 1'b1; #1;
    chk("lit.drop.aok_ch1", 32'(f_up_aok), 32'h2);
    cyc(); f_req = 2'b01; #1;
    chk("lit.drop.aok_ch0", 32'(f_up_aok), 32'h1);
    cyc(); f_req = 2'b00; f_aok = 1'b0; f_dok = 1'b1;
    cyc(); cyc(); f_dok = 1'b0;

    // Full tracker blocks issue, including on the cycle of a pop
    f_req = 2'b01; f_aok = 1'b1;
    repeat (4) cyc();
    chk("lit.full.cnt",    32'(f_cnt), 32'd4);
    chk("lit.full.dn_req", 32'(f_dn_req), 32'd0);
    f_dok = 1'b1; #1;
    chk("lit.full.dn_req_pop", 32'(f_dn_req), 32'd0);
    chk("lit.full.dok",        32'(f_up_dok), 32'h1);
    cyc(); f_dok = 1'b0; #1;
    chk("lit.full.dn_req_after", 32'(f_dn_req), 32'd1);
    chk("lit.full.cnt_after",    32'(f_cnt), 32'd3);
    cyc(); f_req = 2'b00; f_aok = 1'b0;

    // Reset mid-operation loses tracking; stray return flags an error
    resetn = 1'b0; cyc(); resetn = 1'b1; #1;
    chk("lit.rst.cnt",  32'(f_cnt), 32'd0);
    chk("lit.rst.perr", 32'(f_perr), 32'd0);
    f_dok = 1'b1; #1;
    chk("lit.stray.dok", 32'(f_up_dok), 32'd0);
    cyc(); f_dok = 1'b0; #1;
    chk("lit.stray.perr", 32'(f_perr), 32'd1);
    cyc(); #1;
    chk("lit.stray.perr_sticky", 32'(f_perr), 32'd1);
    resetn = 1'b0; cyc(); resetn = 1'b1; #1;
    chk("lit.clr.perr", 32'(f_perr), 32'd0);
    chk("lit.clr.cnt",  32'(f_cnt),  32'd0);

    // Round-robin: all three request continuously, accept every cycle
    r_req = 3'b111; r_aok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      r_dok = (i > 0);
      #1;
      chk("lit.rr.grant", 32'(r_up_aok), 32'd1 << exp_g[i]);
      if (i > 0) chk("lit.rr.ret", 32'(r_up_dok), 32'd1 << exp_g[i-1]);
      cyc();
    end
    r_req = 3'b000; r_aok = 1'b0; r_dok = 1'b1; #1;
    chk("lit.rr.ret_last", 32'(r_up_dok), 32'h4);
    cyc(); r_dok = 1'b0;

    // Issue 1,0,2 with a push and pop together at cnt=2
    r_req = 3'b010; r_aok = 1'b1; #1;
    chk("lit.pp.aok1", 32'(r_up_aok), 32'h2);
    cyc(); r_req = 3'b001; #1;
    chk("lit.pp.aok0", 32'(r_up_aok), 32'h1);
    cyc(); #1;
    chk("lit.pp.cnt2", 32'(r_cnt), 32'd2);
    r_req = 3'b100; r_dok = 1'b1; r_dn_rdata = 32'h55; #1;
    chk("lit.pp.aok2", 32'(r_up_aok), 32'h4);
    chk("lit.pp.dok1", 32'(r_up_dok), 32'h2);
    cyc(); r_req = 3'b000; r_aok = 1'b0; #1;
    chk("lit.pp.cnt_same", 32'(r_cnt), 32'd2);
    chk("lit.pp.dok0", 32'(r_up_dok), 32'h1);
    cyc(); #1;
    chk("lit.pp.dok2", 32'(r_up_dok), 32'h4);
    cyc(); r_dok = 1'b0; #1;
    chk("lit.pp.cnt0", 32'(r_cnt), 32'd0);
    r_dok = 1'b1; #1;
    chk("lit.rr.stray_dok", 32'(r_up_dok), 32'd0);
    cyc(); r_dok = 1'b0; #1;
    chk("lit.rr.perr", 32'(r_perr), 32'd1);
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
Parametrised N-channel arbiter that merges several SRAM-like master ports (inst fetch, data access, future cache refill/TLB walk) onto one SRAM-like slave port. It sits between the CPU core and the bridge/memory side. It generalises the fixed two-port inst/data split to NUM_CH channels, selectable arbitration and multiple outstanding transactions. It tracks outstanding transactions so each data_ok/rdata returns to the issuing channel in order.

Parameters:
NUM_CH, 2, number of upstream master channels (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_OUTST, 4, maximum accepted-but-unreturned transactions (power of 2, >=2)
ARB_MODE, 0, 0 = fixed priority (ch0 highest), 1 = round-robin

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  synchronous active-low reset
up_req  in  NUM_CH  per-channel request
up_wr  in  NUM_CH  per-channel write flag
up_size  in  2*NUM_CH  per-channel size (0 byte, 1 half, 2 word)
up_wstrb  in  4*NUM_CH  per-channel byte strobes
up_addr  in  ADDR_W*NUM_CH  per-channel address
up_wdata  in  DATA_W*NUM_CH  per-channel write data
up_addr_ok  out  NUM_CH  address accepted, one-hot or zero
up_data_ok  out  NUM_CH  transaction returned, one-hot or zero
up_rdata  out  DATA_W  read data, broadcast, valid with up_data_ok
dn_req/dn_wr/dn_size/dn_wstrb/dn_addr/dn_wdata  out  1/1/2/4/ADDR_W/DATA_W  slave request
dn_addr_ok  in  1  slave address accept
dn_data_ok  in  1  slave data return
dn_rdata  in  DATA_W  slave read data
outst_cnt  out  $clog2(MAX_OUTST)+1  current outstanding count
proto_err  out  1  sticky: dn_data_ok seen with no outstanding entry

Behaviour:
- Reset (resetn=0 at clk edge): lock=0, rr_ptr=0, FIFO rd/wr pointers=0, outst_cnt=0, proto_err=0. Combinational outputs then: dn_req=0, up_addr_ok=0, up_data_ok=0.
- Address phase is combinational pass-through (0-cycle latency); dn_* request fields are a mux of the granted channel.
- Grant: when lock=0, winner = ARB_MODE 0: lowest-index up_req; ARB_MODE 1: first requesting channel at or after rr_ptr, wrapping NUM_CH-1 -> 0.
- dn_req = (any granted request) & (outst_cnt < MAX_OUTST). A full FIFO blocks issue even if a pop occurs in the same cycle.
- Lock: if dn_req=1 and dn_addr_ok=0, register lock=1 and lock_id=winner. While locked, the grant is forced to lock_id, so that channel's request stays stable per SRAM-like rules. A lower-index request arriving meanwhile does not preempt it.
- Accept: dn_req & dn_addr_ok -> up_addr_ok[grant]=1 same cycle, push grant id into the ID FIFO, clear lock. In RR mode, rr_ptr <= grant+1 mod NUM_CH.
- Return: dn_data_ok with cnt>0 -> up_data_ok[fifo_head]=1 same cycle, up_rdata=dn_rdata, pop. dn_data_ok with cnt=0 -> no up_data_ok, proto_err<=1 (held until reset).
- Simultaneous push and pop: cnt unchanged, both pointers advance. Pointers wrap modulo MAX_OUTST.
- Write transactions also occupy a FIFO entry and receive up_data_ok (rdata don't-care).
- Reset mid-operation clears all tracking; later dn_data_ok for lost transactions sets proto_err.
- If a locked channel drops up_req (protocol violation), dn_req drops and the lock stays until that channel re-requests and is accepted.

Decomposition:
- Shared package: size encodings (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2), ARB_FIXED=0 / ARB_RR=1 constants, and a clog2 helper.
- One sub-module, outst_id_fifo: synchronous FIFO of width $clog2(NUM_CH) (min 1), depth MAX_OUTST. Provides push/pop/head/count; pop when empty is ignored.

Test Plan:
- Fixed priority, NUM_CH=2, both req, addr_ok immediate -> ch0 gets up_addr_ok at cycle 0; ch1 accepted at cycle 1 after ch0 drops req; data_ok returns route to ch0 then ch1.
- Lock: ch1 alone req at 0x1c000000, dn_addr_ok held low 3 cycles, ch0 raises req at cycle 1 -> dn_addr stays 0x1c000000 and ch1 accepted at cycle 3; ch0 accepted at cycle 4.
- Full: MAX_OUTST=4, 4 accepted reads, no data_ok -> dn_req=0 and outst_cnt=4. One dn_data_ok -> next cycle dn_req=1 again.
- Round-robin, NUM_CH=3, all req continuously, addr_ok every cycle -> grant order 0,1,2,0,1,2.
- Simultaneous push/pop at cnt=2 -> cnt stays 2; return ids remain in issue order (e.g. issued 1,0,2 -> data_ok to 1,0,2).
- dn_data_ok at cnt=0 -> up_data_ok=0 and proto_err=1 next cycle. resetn=0 one cycle -> proto_err=0, outst_cnt=0.
